// File: rtl/gamepad_state_multi.sv
// rtl/gamepad_state_multi.sv - multi-pad button sync, debounce, autofire gating and press-event latches
module gamepad_state_multi #(
  parameter int PAD_COUNT            = 2,
  parameter int BTN_WIDTH            = 12,
  parameter int DEBOUNCE_CYCLES      = 16,
  parameter int AUTOFIRE_HALF_PERIOD = 4096,
  parameter int SEL_WIDTH            = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PAD_COUNT*BTN_WIDTH-1:0] btn_raw,
  input  logic [PAD_COUNT*BTN_WIDTH-1:0] autofire_mask,
  output logic [PAD_COUNT*BTN_WIDTH-1:0] pad_btn,
  input  logic                           read_en,
  input  logic [SEL_WIDTH-1:0]           read_sel,
  output logic                           read_valid,
  output logic [BTN_WIDTH-1:0]           read_pressed
);

  localparam int NBITS = PAD_COUNT * BTN_WIDTH;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int AF_W  = (AUTOFIRE_HALF_PERIOD > 1) ? $clog2(AUTOFIRE_HALF_PERIOD) : 1;
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTOFIRE_HALF_PERIOD - 1);

  logic [NBITS-1:0]     sync1_q, sync2_q;
  logic [NBITS-1:0]     level_q, level_d;
  logic [DB_W-1:0]      db_cnt_q [NBITS];
  logic [DB_W-1:0]      db_cnt_d [NBITS];
  logic [AF_W-1:0]      af_cnt_q, af_cnt_d;
  logic                 af_phase_q, af_phase_d;
  logic [NBITS-1:0]     pad_btn_q, pad_btn_d;
  logic [NBITS-1:0]     latch_q, latch_d;
  logic [NBITS-1:0]     rise, clr;
  logic                 read_valid_q, read_valid_d;
  logic [BTN_WIDTH-1:0] read_pressed_q, read_pressed_d;
  logic [31:0]          sel_ext;

  // Debounce: a level only follows the synchronised input after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NBITS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Autofire timebase: phase flips each time the shared counter wraps
  always_comb begin
    af_cnt_d   = af_cnt_q + AF_W'(1);
    af_phase_d = af_phase_q;
    if (af_cnt_q == AF_LAST) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end
  end

  // Output gating: masked buttons only show while the autofire phase is high
  always_comb begin
    pad_btn_d = level_q & (~autofire_mask | {NBITS{af_phase_q}});
  end

  // Read/clear: snapshot the selected pad's latches, clear them, but a same-cycle rising edge survives
  always_comb begin
    rise           = level_d & ~level_q;
    sel_ext        = 32'(read_sel);
    read_valid_d   = read_en;
    read_pressed_d = read_pressed_q;
    clr            = '0;
    if (read_en) begin
      read_pressed_d = '0;
    end
    for (int p = 0; p < PAD_COUNT; p++) begin
      if (read_en && (sel_ext == 32'(p))) begin
        read_pressed_d                  = latch_q[p*BTN_WIDTH +: BTN_WIDTH];
        clr[p*BTN_WIDTH +: BTN_WIDTH]   = '1;
      end
    end
    latch_d = (latch_q & ~clr) | rise;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      level_q        <= '0;
      af_cnt_q       <= '0;
      af_phase_q     <= 1'b1;
      pad_btn_q      <= '0;
      latch_q        <= '0;
      read_valid_q   <= 1'b0;
      read_pressed_q <= '0;
      for (int i = 0; i < NBITS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q        <= btn_raw;
      sync2_q        <= sync1_q;
      level_q        <= level_d;
      af_cnt_q       <= af_cnt_d;
      af_phase_q     <= af_phase_d;
      pad_btn_q      <= pad_btn_d;
      latch_q        <= latch_d;
      read_valid_q   <= read_valid_d;
      read_pressed_q <= read_pressed_d;
      for (int i = 0; i < NBITS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign pad_btn      = pad_btn_q;
  assign read_valid   = read_valid_q;
  assign read_pressed = read_pressed_q;

endmodule

// File: tb/tb_gamepad_state_multi.sv
// tb/tb_gamepad_state_multi.sv - scoreboard bench for gamepad_state_multi
module tb_gamepad_state_multi;

  localparam int NP = 2;
  localparam int BW = 12;
  localparam int NB = NP * BW;

  typedef struct {
    int            cyc;
    logic [NB-1:0] pb;
    bit            chk_rp;
    logic [BW-1:0] rp;
  } pad_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] autofire_mask;
  logic [NB-1:0] pad_btn;
  logic          read_en;
  logic [2:0]    read_sel;
  logic          read_valid;
  logic [BW-1:0] read_pressed;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int r_cyc = 0;

  logic [BW-1:0] rd_q [$];
  pad_exp_t      pad_q [$];
  pad_exp_t      me;
  logic [BW-1:0] mr;

  gamepad_state_multi #(
    .PAD_COUNT(NP), .BTN_WIDTH(BW), .DEBOUNCE_CYCLES(16),
    .AUTOFIRE_HALF_PERIOD(4), .SEL_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .autofire_mask(autofire_mask),
    .pad_btn(pad_btn), .read_en(read_en), .read_sel(read_sel),
    .read_valid(read_valid), .read_pressed(read_pressed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected read responses on read_valid and timed pad_btn expectations by cycle
  always @(negedge clk) begin
    if (read_valid === 1'b1) begin
      n_vec++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL read_valid cycle %0d got 1 want 0", cyc);
      end else begin
        mr = rd_q.pop_front();
        if (read_pressed !== mr) begin
          n_err++;
          $display("FAIL read_pressed cycle %0d got %03h want %03h", cyc, read_pressed, mr);
        end
      end
    end
    while (pad_q.size() > 0 && pad_q[0].cyc <= cyc) begin
      me = pad_q.pop_front();
      n_vec++;
      if (me.cyc != cyc || pad_btn !== me.pb) begin
        n_err++;
        $display("FAIL pad_btn cycle %0d (due %0d) got %06h want %06h", cyc, me.cyc, pad_btn, me.pb);
      end
      if (me.chk_rp) begin
        n_vec++;
        if (read_pressed !== me.rp) begin
          n_err++;
          $display("FAIL reset_read_pressed cycle %0d got %03h want %03h", cyc, read_pressed, me.rp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pad(input int at, input logic [NB-1:0] pb);
    pad_exp_t e;
    e.cyc = at; e.pb = pb; e.chk_rp = 1'b0; e.rp = '0;
    pad_q.push_back(e);
  endtask

  task automatic expect_reset(input int at);
    pad_exp_t e;
    e.cyc = at; e.pb = '0; e.chk_rp = 1'b1; e.rp = '0;
    pad_q.push_back(e);
  endtask

  task automatic do_read(input logic [2:0] sel, input logic [BW-1:0] exp);
    read_en  = 1'b1;
    read_sel = sel;
    rd_q.push_back(exp);
    tick(1);
    read_en  = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [NB-1:0] v;
    reset = 1'b0; btn_raw = '0; autofire_mask = '0; read_en = 1'b0; read_sel = '0;

    // Reset state, then an empty read of pad 0
    tick(3);
    expect_reset(cyc);
    r_cyc = cyc;
    reset = 1'b1;
    expect_pad(cyc + 1, '0);
    do_read(3'd0, 12'h000);
    tick(2);

    // Pad 1 bit 3 held: pad_btn bit 15 rises exactly 19 cycles later
    k = cyc;
    btn_raw[15] = 1'b1;
    expect_pad(k + 18, 24'h000000);
    expect_pad(k + 19, 24'h008000);
    tick(25);

    // 10-cycle pulse on pad 1 bit 0 never reaches the output
    k = cyc;
    btn_raw[12] = 1'b1;
    for (int i = 1; i <= 30; i++) expect_pad(k + i, 24'h008000);
    tick(10);
    btn_raw[12] = 1'b0;
    tick(25);

    // Press and release pad 0 bit 0, then two back-to-back reads
    k = cyc;
    btn_raw[0] = 1'b1;
    expect_pad(k + 19, 24'h008001);
    tick(20);
    k = cyc;
    btn_raw[0] = 1'b0;
    expect_pad(k + 18, 24'h008001);
    expect_pad(k + 19, 24'h008000);
    tick(20);
    do_read(3'd0, 12'h001);
    do_read(3'd0, 12'h000);
    tick(2);

    // Read coincides with pad 0 bit 5 level rising: event deferred to next read
    k = cyc;
    btn_raw[5] = 1'b1;
    expect_pad(k + 18, 24'h008000);
    expect_pad(k + 19, 24'h008020);
    tick(17);
    do_read(3'd0, 12'h000);
    do_read(3'd0, 12'h020);
    k = cyc;
    btn_raw[5] = 1'b0;
    expect_pad(k + 19, 24'h008000);
    tick(22);

    // Autofire on pad 0 bit 2: phase high for 4 cycles, low for 4, counted from reset
    k = cyc;
    btn_raw[2] = 1'b1;
    autofire_mask[2] = 1'b1;
    tick(20);
    for (int c = k + 21; c <= k + 36; c++) begin
      v = 24'h008000;
      if ((((c - 1 - r_cyc) / 4) % 2) == 0) v[2] = 1'b1;
      expect_pad(c, v);
    end
    tick(17);
    k = cyc;
    autofire_mask[2] = 1'b0;
    for (int i = 1; i <= 8; i++) expect_pad(k + i, 24'h008004);
    tick(10);

    // Out-of-range select leaves both pads' latches intact
    do_read(3'd5, 12'h000);
    do_read(3'd0, 12'h004);
    do_read(3'd1, 12'h008);
    tick(2);

    // Reset mid-debounce with a latch set and a read in flight
    btn_raw[7] = 1'b1;
    tick(20);
    btn_raw[23] = 1'b1;
    tick(8);
    k = cyc;
    reset = 1'b0;
    btn_raw = '0;
    read_en = 1'b1;
    read_sel = 3'd0;
    expect_reset(k + 1);
    tick(1);
    reset = 1'b1;
    read_en = 1'b0;
    for (int i = 1; i <= 5; i++) expect_pad(k + 1 + i, '0);
    tick(6);
    do_read(3'd0, 12'h000);
    do_read(3'd1, 12'h000);
    tick(3);

    n_vec++;
    if (rd_q.size() != 0 || pad_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d/%0d pending want 0/0", rd_q.size(), pad_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
